adder_arbiter: RTL and testbench

Shares one 16-bit Adder instance between NREQ requesters, e.g. PC+1, branch target and load/store address calculation in the pipeline. Requesters are served round-robin over a valid/ready handshake. Each result is returned through a one-entry registered response port, tagged with the requester ID. Sits between the decode/execute stages and the shared Adder.

---
 rtl/adder_arb_pkg.sv | 27 ++
 rtl/adder_arbiter_adder.sv | 10 +
 rtl/adder_arbiter_rr_arbiter.sv | 36 +++
 rtl/adder_arbiter.sv | 128 ++++++++++++
 tb/tb_adder_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared constants and types for the round-robin adder arbiter.
// The response bundle always carries flag bits; they stay zero unless ADDER_ARB_FLAGS_EN is defined.
package adder_arb_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREQ_DEF  = 3;
    localparam int NREQ_MAX  = 8;
    localparam int ID_W_MAX  = 3;

    // Requester tag width; never narrower than one bit.
    function automatic int id_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    typedef struct packed {
        logic cout;
        logic ovf;
        logic z;
    } flags_t;

    typedef struct packed {
        logic [ID_W_MAX-1:0]  id;
        logic [WIDTH_DEF-1:0] sum;
        flags_t               flags;
    } rsp_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// The single shared 16-bit adder; unsigned, wraps modulo 2^16.
module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping.
// The pointer itself lives in the parent; enable gates the one-hot grant only.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        found   = 1'b0;
        idx     = 0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        gnt = '0;
        if (enable && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one 16-bit adder between NREQ requesters, round-robin, with a one-entry response register.
// Optional status flags (carry, signed overflow, zero) are enabled by defining ADDER_ARB_FLAGS_EN.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = id_width(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_sum
`ifdef ADDER_ARB_FLAGS_EN
    ,
    output logic                  rsp_cout,
    output logic                  rsp_ovf,
    output logic                  rsp_z
`endif
);

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_sum;
    flags_t           flags_now;

    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  ptr_next;
    logic             rsp_valid_reg;
    logic             rsp_valid_next;
    rsp_t             rsp_reg;
    rsp_t             rsp_next;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    // A full register that is being popped this cycle can take a new result.
    assign can_accept = !rsp_valid_reg || rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_reg),
        .enable  (can_accept && reset),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign op_a      = a_arr[gnt_idx];
    assign op_b      = b_arr[gnt_idx];

    adder16 u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

`ifdef ADDER_ARB_FLAGS_EN
    // Carry recovered from the MSBs: a carry into bit 15 shows up as an inverted sum bit.
    always_comb begin
        flags_now.cout = (op_a[WIDTH-1] & op_b[WIDTH-1])
                       | ((op_a[WIDTH-1] | op_b[WIDTH-1]) & ~add_sum[WIDTH-1]);
        flags_now.ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
        flags_now.z    = (add_sum == '0);
    end

    assign rsp_cout = rsp_reg.flags.cout;
    assign rsp_ovf  = rsp_reg.flags.ovf;
    assign rsp_z    = rsp_reg.flags.z;
`else
    assign flags_now = '0;
`endif

    always_comb begin
        ptr_next       = ptr_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_next       = rsp_reg;
        if (xfer) begin
            rsp_valid_next = 1'b1;
            rsp_next.id    = ID_W_MAX'(gnt_idx);
            rsp_next.sum   = add_sum;
            rsp_next.flags = flags_now;
            ptr_next       = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_reg       <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_reg       <= rsp_next;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_reg.id[ID_W-1:0];
    assign rsp_sum   = rsp_reg.sum;

    // Tag bits above ID_W (and flags in the base build) are intentionally unread.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^{rsp_reg.id, rsp_reg.flags};

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_adder_arbiter;

    localparam int NREQ  = 3;
    localparam int WIDTH = 16;
    localparam int ID_W  = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
`ifdef ADDER_ARB_FLAGS_EN
    logic                  rsp_cout;
    logic                  rsp_ovf;
    logic                  rsp_z;
`endif

    int errors = 0;
    int checks = 0;

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
`ifdef ADDER_ARB_FLAGS_EN
        ,
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_z     (rsp_z)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid;
    int m_id;
    int m_sum;
    bit m_cout, m_ovf, m_z;
    int m_ptr;

    function automatic int model_pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_id = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_z = 0; m_ptr = 0;
    endtask

    initial model_clear();

    always begin
        int g;
        bit can;
        logic [31:0] exp_ready;
        @(negedge clock);
        if (!reset) model_clear();
        g = model_pick();
        can = !m_valid || rsp_ready;
        exp_ready = (reset && can && g >= 0) ? (32'd1 << g) : 32'd0;
        check("cyc_req_ready", 32'(req_ready), exp_ready);
        check("cyc_rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            check("cyc_rsp_id", 32'(rsp_id), 32'(m_id));
            check("cyc_rsp_sum", 32'(rsp_sum), 32'(m_sum));
`ifdef ADDER_ARB_FLAGS_EN
            check("cyc_rsp_cout", 32'(rsp_cout), 32'(m_cout));
            check("cyc_rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
            check("cyc_rsp_z", 32'(rsp_z), 32'(m_z));
`endif
        end
        @(posedge clock);
        if (!reset) begin
            model_clear();
        end else begin
            g = model_pick();
            can = !m_valid || rsp_ready;
            if (can && g >= 0) begin
                int a, b, s;
                a = int'(req_a[g*WIDTH +: WIDTH]);
                b = int'(req_b[g*WIDTH +: WIDTH]);
                s = a + b;
                m_valid = 1;
                m_id    = g;
                m_sum   = s % 65536;
                m_cout  = (s > 65535);
                m_z     = (m_sum == 0);
                m_ovf   = ((a >= 32768) == (b >= 32768)) && ((m_sum >= 32768) != (a >= 32768));
                m_ptr   = (g + 1) % NREQ;
            end else if (m_valid && rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
        req_valid[i] = v;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    initial begin
        logic [15:0] rr_sum [3];
        rr_sum[0] = 16'h1001; rr_sum[1] = 16'h2002; rr_sum[2] = 16'h3003;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        step(); step();
        reset = 1'b1;

        // Round robin with all requesters valid and a consumer that never stalls.
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 16'h1000, 16'h0001);
        set_req(1, 1'b1, 16'h2000, 16'h0002);
        set_req(2, 1'b1, 16'h3000, 16'h0003);
        for (int k = 0; k < 6; k++) begin
            #2 check("rr_grant", 32'(req_ready), 32'd1 << (k % 3));
            step();
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_rsp_id", 32'(rsp_id), 32'(k % 3));
            check("rr_rsp_sum", 32'(rsp_sum), 32'(rr_sum[k % 3]));
        end

        // Signed overflow case from requester 1 alone.
        req_valid = '0;
        set_req(1, 1'b1, 16'h7FFF, 16'h0001);
        #2 check("ovf_grant", 32'(req_ready), 32'b010);
        step();
        check("ovf_sum", 32'(rsp_sum), 32'h8000);
        check("ovf_id", 32'(rsp_id), 32'd1);
`ifdef ADDER_ARB_FLAGS_EN
        check("ovf_flag_ovf", 32'(rsp_ovf), 32'd1);
        check("ovf_flag_cout", 32'(rsp_cout), 32'd0);
        check("ovf_flag_z", 32'(rsp_z), 32'd0);
`endif

        // Pointer now at 2; only req0 valid must wrap, with unsigned wrap-around sum.
        req_valid = '0;
        set_req(0, 1'b1, 16'hFFFF, 16'h0001);
        #2 check("wrap_grant", 32'(req_ready), 32'b001);
        step();
        check("wrap_sum", 32'(rsp_sum), 32'h0000);
        check("wrap_id", 32'(rsp_id), 32'd0);
`ifdef ADDER_ARB_FLAGS_EN
        check("wrap_flag_cout", 32'(rsp_cout), 32'd1);
        check("wrap_flag_z", 32'(rsp_z), 32'd1);
        check("wrap_flag_ovf", 32'(rsp_ovf), 32'd0);
`endif
        req_valid = 3'b011;
        #2 check("ptr1_grant", 32'(req_ready), 32'b010);
        step();
        check("ptr1_id", 32'(rsp_id), 32'd1);
        check("ptr1_sum", 32'(rsp_sum), 32'h8000);

        // Backpressure: response held, nobody granted.
        req_valid = 3'b101;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2 check("bp_grant", 32'(req_ready), 32'd0);
            step();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_id", 32'(rsp_id), 32'd1);
            check("bp_sum", 32'(rsp_sum), 32'h8000);
        end
        rsp_ready = 1'b1;
        #2 check("bp_release_grant", 32'(req_ready), 32'b100);
        step();
        check("bp_release_valid", 32'(rsp_valid), 32'd1);
        check("bp_release_id", 32'(rsp_id), 32'd2);
        check("bp_release_sum", 32'(rsp_sum), 32'h3003);

        // Asynchronous reset while a response is pending.
        req_valid = 3'b001;
        set_req(0, 1'b1, 16'h1000, 16'h0234);
        step();
        rsp_ready = 1'b0;
        req_valid = '0;
        check("pre_reset_sum", 32'(rsp_sum), 32'h1234);
        #1 reset = 1'b0;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rsp_sum", 32'(rsp_sum), 32'd0);
        check("async_rsp_id", 32'(rsp_id), 32'd0);
        check("async_req_ready", 32'(req_ready), 32'd0);
        step();
        reset = 1'b1;
        req_valid = 3'b111;
        #2 check("post_reset_grant", 32'(req_ready), 32'b001);
        step();

        // Randomized traffic, including occasional single-cycle reset pulses.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic [15:0] a, b;
                a = 16'($urandom);
                b = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: a = 16'hFFFF;
                    1: a = 16'h7FFF;
                    2: b = 16'(-a);
                    default: ;
                endcase
                set_req(i, 1'($urandom_range(0, 99) < 55), a, b);
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            reset = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1;
        req_valid = '0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
